// File: rtl/debug_recolector.sv
// Debug word collector: streams the GPRs, then the first cant_mem_datos data-memory words.
// Define RECOLECTOR_CHECKSUM_EN to build the running XOR checksum of captured words.
module debug_recolector #(
  parameter int unsigned len            = 32,
  parameter int unsigned cant_regs      = 32,
  parameter int unsigned cant_mem_datos = 16,
  parameter int unsigned NB_regs        = $clog2(cant_regs),
  parameter int unsigned NB_mem         = $clog2(cant_mem_datos),
  parameter int unsigned NB_idx         = $clog2(cant_regs + cant_mem_datos + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart_recolector,
  input  logic               enable_next_recolector,
  input  logic [len-1:0]     reg_data,
  input  logic [len-1:0]     mem_data,
  output logic [NB_regs-1:0] reg_addr,
  output logic [NB_mem-1:0]  mem_addr,
  output logic [len-1:0]     recolector,
  output logic               recolector_valid,
  output logic               recolector_done,
  output logic [len-1:0]     checksum
);

  localparam logic [NB_idx-1:0] RegsIdx  = NB_idx'(cant_regs);
  localparam logic [NB_idx-1:0] TotalIdx = NB_idx'(cant_regs + cant_mem_datos);

  typedef enum logic [1:0] {StFetch, StWaitMem, StHold, StDone} state_e;

  state_e             state_q, state_d;
  logic [NB_idx-1:0]  index_q, index_d, idx_inc;
  logic [NB_regs-1:0] reg_addr_q, reg_addr_d;
  logic [NB_mem-1:0]  mem_addr_q, mem_addr_d;
  logic [len-1:0]     recolector_q, recolector_d, cap_word;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               pending_q, pending_d;
  logic               en_q;
  logic               adv, capture;

  assign adv = enable_next_recolector & ~en_q;

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    reg_addr_d   = reg_addr_q;
    mem_addr_d   = mem_addr_q;
    recolector_d = recolector_q;
    valid_d      = valid_q;
    done_d       = done_q;
    pending_d    = pending_q;
    capture      = 1'b0;
    cap_word     = '0;
    idx_inc      = index_q + NB_idx'(1);

    if (restart_recolector) begin
      state_d    = StFetch;
      index_d    = '0;
      reg_addr_d = '0;
      mem_addr_d = '0;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      pending_d  = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (adv) pending_d = 1'b1;
          if (index_q < RegsIdx) begin
            capture  = 1'b1;
            cap_word = reg_data;
            state_d  = StHold;
          end else begin
            // RAM registers mem_addr on this edge; data is ready next cycle
            state_d = StWaitMem;
          end
        end
        StWaitMem: begin
          if (adv) pending_d = 1'b1;
          capture  = 1'b1;
          cap_word = mem_data;
          state_d  = StHold;
        end
        StHold: begin
          if (adv || pending_q) begin
            pending_d = 1'b0;
            valid_d   = 1'b0;
            index_d   = idx_inc;
            if (idx_inc == TotalIdx) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StFetch;
              if (idx_inc < RegsIdx) reg_addr_d = NB_regs'(idx_inc);
              else                   mem_addr_d = NB_mem'(idx_inc - RegsIdx);
            end
          end
        end
        StDone: begin
          valid_d = 1'b0;
        end
        default: state_d = StFetch;
      endcase

      if (capture) begin
        recolector_d = cap_word;
        valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StFetch;
      index_q      <= '0;
      reg_addr_q   <= '0;
      mem_addr_q   <= '0;
      recolector_q <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      pending_q    <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      reg_addr_q   <= reg_addr_d;
      mem_addr_q   <= mem_addr_d;
      recolector_q <= recolector_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      pending_q    <= pending_d;
      en_q         <= enable_next_recolector;
    end
  end

`ifdef RECOLECTOR_CHECKSUM_EN
  logic [len-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (restart_recolector) checksum_d = '0;
    else if (capture)       checksum_d = checksum_q ^ cap_word;
  end

  always_ff @(posedge clk) begin
    if (!reset) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign reg_addr         = reg_addr_q;
  assign mem_addr         = mem_addr_q;
  assign recolector       = recolector_q;
  assign recolector_valid = valid_q;
  assign recolector_done  = done_q;

endmodule

// File: tb/tb_debug_recolector.sv
// Self-checking bench for debug_recolector: cycle tables, latency sequences and randomized walks.
module tb_debug_recolector;

  localparam int NREGS = 32;
  localparam int NMEM  = 16;
  localparam int TOTAL = NREGS + NMEM;

  logic        clk = 1'b0;
  logic        reset, restart, en;
  logic [31:0] reg_data, mem_data;
  logic [4:0]  reg_addr;
  logic [3:0]  mem_addr;
  logic [31:0] recolector, checksum;
  logic        valid, done;

  logic [31:0] regs [NREGS];
  logic [31:0] mem  [NMEM];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign reg_data = regs[reg_addr];
  always @(posedge clk) mem_data <= mem[mem_addr];

  debug_recolector dut (
    .clk                    (clk),
    .reset                  (reset),
    .restart_recolector     (restart),
    .enable_next_recolector (en),
    .reg_data               (reg_data),
    .mem_data               (mem_data),
    .reg_addr               (reg_addr),
    .mem_addr               (mem_addr),
    .recolector             (recolector),
    .recolector_valid       (valid),
    .recolector_done        (done),
    .checksum               (checksum)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        rs;
    logic        exp_valid;
    logic        exp_done;
    logic [4:0]  exp_ra;
    logic [3:0]  exp_ma;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vq[$];

  // Stream order: GPRs first, then memory words.
  function automatic logic [31:0] word_at(input int k);
    return (k < NREGS) ? regs[k] : mem[k-NREGS];
  endfunction

  function automatic logic [31:0] exp_ck(input int k);
    logic [31:0] x;
    x = '0;
`ifdef RECOLECTOR_CHECKSUM_EN
    for (int i = 0; i <= k; i++) x = x ^ word_at(i);
`endif
    return x;
  endfunction

  function automatic logic [4:0] exp_ra(input int k);
    return (k < NREGS) ? 5'(k) : 5'(NREGS - 1);
  endfunction

  function automatic logic [3:0] exp_ma(input int k);
    if (k < NREGS) return 4'd0;
    if (k < TOTAL) return 4'(k - NREGS);
    return 4'(NMEM - 1);
  endfunction

  function automatic void add(input logic r, input logic e, input logic s, input logic v,
                              input logic d, input logic [4:0] ra, input logic [3:0] ma,
                              input logic [31:0] w);
    vq.push_back('{r, e, s, v, d, ra, ma, w});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic ed,
                           input logic [4:0] era, input logic [3:0] ema, input logic [31:0] ew);
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".reg_addr"}, 32'(reg_addr), 32'(era));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(ema));
    chk({tag, ".word"}, recolector, ew);
  endtask

  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      reset   = vq[i].rst_n;
      en      = vq[i].en;
      restart = vq[i].rs;
      tick();
      chk_state(tag, vq[i].exp_valid, vq[i].exp_done, vq[i].exp_ra, vq[i].exp_ma,
                vq[i].exp_word);
    end
    vq.delete();
  endtask

  // Request word k with an enable pulse of the given width, checking exact latency.
  task automatic advance(input int k, input int width);
    int lat;
    lat = (k >= TOTAL) ? 1 : ((k < NREGS) ? 2 : 3);
    en  = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      tick();
      en = (c < width);
      if (c < lat)
        chk_state("adv_wait", 1'b0, 1'b0, exp_ra(k), exp_ma(k), word_at(k-1));
      else if (k >= TOTAL)
        chk_state("adv_done", 1'b0, 1'b1, exp_ra(k), exp_ma(k), word_at(TOTAL-1));
      else
        chk_state("adv_word", 1'b1, 1'b0, exp_ra(k), exp_ma(k), word_at(k));
    end
    chk("adv_checksum", checksum, exp_ck((k >= TOTAL) ? TOTAL-1 : k));
    en = 1'b0;
  endtask

  task automatic idle(input int n, input int k);
    en = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (k < TOTAL) chk_state("idle", 1'b1, 1'b0, exp_ra(k), exp_ma(k), word_at(k));
      else           chk_state("idle_done", 1'b0, 1'b1, exp_ra(k), exp_ma(k), word_at(TOTAL-1));
    end
  endtask

  task automatic post_done_pulse();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    chk_state("post_done", 1'b0, 1'b1, exp_ra(TOTAL), exp_ma(TOTAL), word_at(TOTAL-1));
    chk("post_done.ck", checksum, exp_ck(TOTAL-1));
  endtask

  task automatic start(input bit use_reset);
    en = 1'b0;
    if (use_reset) begin
      reset = 1'b0;
      tick();
      chk_state("reset", 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
      chk("reset.ck", checksum, 32'd0);
      reset = 1'b1;
    end else begin
      restart = 1'b1;
      tick();
      chk("restart.valid", 32'(valid), 32'd0);
      chk("restart.done", 32'(done), 32'd0);
      chk("restart.reg_addr", 32'(reg_addr), 32'd0);
      chk("restart.ck", checksum, 32'd0);
      restart = 1'b0;
    end
    tick();
    chk_state("first", 1'b1, 1'b0, 5'd0, 4'd0, word_at(0));
    chk("first.ck", checksum, exp_ck(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int aborts;
    reset   = 1'b0;
    restart = 1'b0;
    en      = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = 32'h100 + 32'(i);
    for (int i = 0; i < NMEM; i++) mem[i] = 32'hA000_0000 + 32'(i);

    // Reset, auto-start, enable held for 20 cycles gives exactly one advance.
    add(0, 0, 0, 0, 0, 5'd0, 4'd0, 32'h0);
    add(0, 0, 0, 0, 0, 5'd0, 4'd0, 32'h0);
    add(1, 0, 0, 1, 0, 5'd0, 4'd0, 32'h100);
    add(1, 1, 0, 0, 0, 5'd1, 4'd0, 32'h100);
    add(1, 1, 0, 1, 0, 5'd1, 4'd0, 32'h101);
    for (int i = 0; i < 18; i++) add(1, 1, 0, 1, 0, 5'd1, 4'd0, 32'h101);
    add(1, 0, 0, 1, 0, 5'd1, 4'd0, 32'h101);
    add(1, 1, 0, 0, 0, 5'd2, 4'd0, 32'h101);
    add(1, 0, 0, 1, 0, 5'd2, 4'd0, 32'h102);
    run_table("tbl_start");

    // Remaining GPRs plus the first memory word, pulses spaced 10 cycles apart.
    for (k = 3; k <= NREGS; k++) begin
      advance(k, 1);
      idle((k < NREGS) ? 8 : 7, k);
    end

    // Pulses landing in WAIT_MEM and FETCH become pending; an edge seen while
    // pending is already set merges into the same single advance.
    add(1, 1, 0, 0, 0, 5'd31, 4'd1, 32'hA000_0000);
    add(1, 0, 0, 0, 0, 5'd31, 4'd1, 32'hA000_0000);
    add(1, 1, 0, 1, 0, 5'd31, 4'd1, 32'hA000_0001);
    add(1, 0, 0, 0, 0, 5'd31, 4'd2, 32'hA000_0001);
    add(1, 1, 0, 0, 0, 5'd31, 4'd2, 32'hA000_0001);
    add(1, 0, 0, 1, 0, 5'd31, 4'd2, 32'hA000_0002);
    add(1, 1, 0, 0, 0, 5'd31, 4'd3, 32'hA000_0002);
    add(1, 0, 0, 0, 0, 5'd31, 4'd3, 32'hA000_0002);
    add(1, 0, 0, 1, 0, 5'd31, 4'd3, 32'hA000_0003);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 0, 5'd31, 4'd3, 32'hA000_0003);
    run_table("tbl_pending");

    for (k = 36; k <= TOTAL; k++) begin
      advance(k, 1);
      idle(2, k);
    end
    post_done_pulse();
    post_done_pulse();

    // Restart out of DONE, walk to index 40, then restart together with enable.
    start(1'b0);
    for (k = 1; k <= 40; k++) begin
      advance(k, 1);
      idle(1, k);
    end
    restart = 1'b1;
    en      = 1'b1;
    tick();
    chk("rs40.valid", 32'(valid), 32'd0);
    chk("rs40.reg_addr", 32'(reg_addr), 32'd0);
    chk("rs40.mem_addr", 32'(mem_addr), 32'd0);
    chk("rs40.ck", checksum, 32'd0);
    tick();
    chk("rs40.held_valid", 32'(valid), 32'd0);
    restart = 1'b0;
    en      = 1'b0;
    tick();
    chk_state("rs40.first", 1'b1, 1'b0, 5'd0, 4'd0, 32'h100);
    chk("rs40.first_ck", checksum, exp_ck(0));

    // Randomized contents, pulse widths, gaps and mid-stream aborts.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
      for (int i = 0; i < NMEM; i++) mem[i] = $urandom;
      start((it % 2) == 1);
      k      = 0;
      aborts = 0;
      while (k < TOTAL) begin
        if (aborts < 2 && $urandom_range(0, 23) == 0) begin
          aborts++;
          start($urandom_range(0, 1) == 1);
          k = 0;
        end else begin
          k++;
          advance(k, int'($urandom_range(1, 3)));
          idle(int'($urandom_range(1, 4)), k);
        end
      end
      post_done_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
